vga_sync_gen: RTL

//  Display-side timing master for the frame buffer: generates 640x480@60 VGA sync (25 MHz pixel clock),

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_sync_gen_if.sv | 29 ++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, phase encoding and small helpers for the VGA sync generator.
// Counters are 10 bits wide, which covers the 800-clock line and the 525-line frame.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int POS_W = 10;
    localparam int RGB_W = 4;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic bright;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, bright: 1'b0};

    function automatic logic [RGB_W-1:0] expand_pixel(input logic [1:0] pix);
        return {pix, pix};
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-side and monitor-side signals of the sync generator.
// The generator is the master; the frame buffer / DAC side is the slave.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic [1:0]       pixel_in;
    logic             bright;
    logic [POS_W-1:0] x_pos;
    logic [POS_W-1:0] y_pos;
    logic             frame_start;
    logic             vga_hs;
    logic             vga_vs;
    logic [RGB_W-1:0] vga_r;
    logic [RGB_W-1:0] vga_g;
    logic [RGB_W-1:0] vga_b;

    modport master (
        input  pixel_in,
        output bright, x_pos, y_pos, frame_start,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

    modport slave (
        output pixel_in,
        input  bright, x_pos, y_pos, frame_start,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FP/SYNC/BP phase, stepping when 'advance' is high.
// The next phase is exported so the parent can register decoded strobes glitch-free.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [POS_W-1:0] count,
    output phase_t           phase_next,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] FP_START   = POS_W'(ACTIVE);
    localparam logic [POS_W-1:0] SYNC_START = POS_W'(ACTIVE + FP);
    localparam logic [POS_W-1:0] BP_START   = POS_W'(ACTIVE + FP + SYNC);

    logic [POS_W-1:0] count_reg;
    logic [POS_W-1:0] count_next;
    phase_t           phase_reg;

    assign wrap  = advance && (count_reg == LAST);
    assign count = count_reg;

    // Phase boundaries come from counter compares, so the wrap always forces ACTIVE.
    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        if (advance) begin
            if (count_reg >= LAST) begin
                count_next = '0;
                phase_next = PH_ACTIVE;
            end else begin
                count_next = count_reg + 1'b1;
                if (count_next == FP_START) begin
                    phase_next = PH_FP;
                end else if (count_next == SYNC_START) begin
                    phase_next = PH_SYNC;
                end else if (count_next == BP_START) begin
                    phase_next = PH_BP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            phase_reg <= PH_ACTIVE;
        end else begin
            count_reg <= count_next;
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: x/y counters, registered bright/frame_start, and sync/colour outputs
// delayed PIX_LAT clocks to line up with the frame buffer's read latency.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIX_LAT  = 1
) (
    input  logic         clk_25,
    input  logic         reset_n,
    vga_sync_gen_if.master vga
);

    logic             running_reg;
    logic             bright_reg;
    logic             frame_start_reg;
    logic             hs_raw_reg;
    logic             vs_raw_reg;
    logic [POS_W-1:0] h_count;
    logic [POS_W-1:0] v_count;
    phase_t           h_phase_next;
    phase_t           v_phase_next;
    logic             h_wrap;
    logic             v_wrap;

    // Counters hold at 0,0 for the first clock after reset so that clock shows frame_start.
    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk        (clk_25),
        .rst_n      (reset_n),
        .advance    (running_reg),
        .count      (h_count),
        .phase_next (h_phase_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk        (clk_25),
        .rst_n      (reset_n),
        .advance    (h_wrap),
        .count      (v_count),
        .phase_next (v_phase_next),
        .wrap       (v_wrap)
    );

    // Strobes decode the next phase so each is a plain flop aligned with the new x/y.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            running_reg     <= 1'b0;
            bright_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            hs_raw_reg      <= 1'b1;
            vs_raw_reg      <= 1'b1;
        end else begin
            running_reg     <= 1'b1;
            bright_reg      <= (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
            frame_start_reg <= v_wrap || !running_reg;
            hs_raw_reg      <= (h_phase_next != PH_SYNC);
            vs_raw_reg      <= (v_phase_next != PH_SYNC);
        end
    end

    sync_t sync_raw;
    sync_t sync_out;

    assign sync_raw = '{hs: hs_raw_reg, vs: vs_raw_reg, bright: bright_reg};

    generate
        if (PIX_LAT == 0) begin : g_no_delay
            assign sync_out = sync_raw;
        end else begin : g_delay
            sync_t stage_reg [PIX_LAT];

            always_ff @(posedge clk_25 or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        stage_reg[i] <= SYNC_IDLE;
                    end
                end else begin
                    stage_reg[0] <= sync_raw;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign sync_out = stage_reg[PIX_LAT-1];
        end
    endgenerate

    // Blanking gate sits after the last delay flop so colour follows pixel_in with no extra clock.
    logic [RGB_W-1:0] colour;
    assign colour = sync_out.bright ? expand_pixel(vga.pixel_in) : '0;

    assign vga.bright      = bright_reg;
    assign vga.x_pos       = h_count;
    assign vga.y_pos       = v_count;
    assign vga.frame_start = frame_start_reg;
    assign vga.vga_hs      = sync_out.hs;
    assign vga.vga_vs      = sync_out.vs;
    assign vga.vga_r       = colour;
    assign vga.vga_g       = colour;
    assign vga.vga_b       = colour;

endmodule
